rf_pulse_gate: RTL and testbench
================================

// Module: rf_pulse_gate
// PURPOSE
//  Transmit-pulse gate between the 8-lane parallel sin/cos DDS generator and the DAC interface.
//  Consumes 8x16-bit I/Q sample words per clk (dds_i/dds_q/dds_valid).
//  Per NMR pulse, applies the programmed delay, phase (0/90/180/270 deg) and amplitude for exactly pulse_len clk cycles.
//  Outputs zeros otherwise; drives amplifier gate and start/busy/done handshake to the sequencer.
// PARAMETERS
//  NLANE      8   samples per clk word
//  SW         16  signed sample width (two's complement)
//  AW         16  unsigned amplitude width; 0xFFFF ~= unity
//  CW         32  delay/pulse counter width
//  GATE_LEAD  4   gate lead cycles (only with RF_GATE_LEAD_EN)
// PORTS
//  clk        in   1         system clock
//  rst_n      in   1         asynchronous active-low reset
//  dds_i      in   NLANE*SW  sine lanes, lane0 = [15:0] = earliest sample
//  dds_q      in   NLANE*SW  cosine lanes, same ordering
//  dds_valid  in   1         DDS sample word valid
//  start      in   1         pulse request; accepted only in IDLE with dds_valid=1
//  delay_len  in   CW        cycles between accept and first pulse cycle
//  pulse_len  in   CW        pulse duration in clk cycles
//  phase_sel  in   2         0:+I 1:+Q 2:-I 3:-Q
//  amplitude  in   AW        amplitude scale
//  busy       out  1         high from accept until pipeline drained
//  done       out  1         1-cycle pulse, aligned with last gated dac_data word
//  err        out  1         sticky: pulse aborted by dds_valid loss
//  dac_data   out  NLANE*SW  gated, scaled samples; 0 outside the pulse window
//  dac_valid  out  1         dds_valid delayed 2 cycles
//  gate       out  1         amplifier enable
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=IDLE, counters 0, pipeline cleared at once, including mid-pulse.
//  Accept (cycle T): in IDLE with start=1 and dds_valid=1.
//   - Latch delay_len/pulse_len/phase_sel/amplitude; err<=0.
//   - start is ignored when not in IDLE or when dds_valid=0.
//  FSM IDLE->DELAY->PULSE->IDLE:
//   - DELAY lasts exactly delay_len cycles; delay_len=0 skips to PULSE at T+1.
//   - PULSE lasts exactly pulse_len cycles; first PULSE cycle is T+1+delay_len.
//   - pulse_len=0: no gated output, gate stays 0; done still pulses at T+3+delay_len.
//  Latency: input word in PULSE cycle t appears on dac_data at t+2.
//   - Stage 1: phase select/negate.
//   - Stage 2: multiply and truncate.
//   - gate and done are pipelined with the same 2-cycle alignment.
//  Arithmetic:
//   - Negation saturates: -(-32768) = +32767.
//   - out = (s * {1'b0,amplitude}) >>> 16, signed, truncated toward -inf.
//   - Result always fits SW bits; no overflow possible.
//  Abort: dds_valid=0 in DELAY or PULSE -> next cycle IDLE, err<=1, done not pulsed.
//   - Words already in the pipeline are flushed to 0.
//   - gate drops 2 cycles after the abort cycle (same pipeline alignment).
//  busy = (FSM!=IDLE) | any pipeline window bit. A new start is accepted only once busy=0.
//  Counters are CW bits; max delay/pulse = 2^CW-1, no wrap.
// CONFIGURATION
//  RF_GATE_LEAD_EN defined:
//   - gate rises GATE_LEAD cycles before the first gated dac_data word and falls with the last one.
//   - If delay_len+2 < GATE_LEAD, gate rises the cycle after accept.
//  RF_GATE_LEAD_EN undefined: gate high exactly while gated (pulse-window) words are on dac_data.
// STRUCTURE
//  Shared include rf_tx_defs.vh holds:
//   - FSM state localparams IDLE/DELAY/PULSE.
//   - Phase codes PH_0/PH_90/PH_180/PH_270.
//   - SW/AW defaults.
//  Sub-module rf_lane_scale: one lane of saturating phase-negate + multiply, 2-stage, generated NLANE times.
//  Top holds FSM, counters, param latches and window/gate/done pipeline.
// TESTING
//  1 delay=3, pulse=5, ph=0, amp=FFFF, lanes=0x4000:
//    -> T+6..T+10: dac_data lanes=0x3FFF, gate=1, done at T+10, busy low at T+11.
//  2 ph=2, lane=0x8000, amp=FFFF -> lane out 0x7FFE (saturated negate then scale); ph=3 with lane q=0x1000, amp=8000 -> 0xF800.
//  3 dds_valid=0 at 2nd PULSE cycle -> err=1, no done, dac_data=0 from +2, next start clears err.
//  4 pulse_len=0, delay=0 -> gate never 1, done at T+3; start held high while busy -> no re-accept.
//  5 rst_n=0 mid-PULSE -> outputs 0 same cycle; after release, FSM IDLE; accept works next cycle.
//  6 RF_GATE_LEAD_EN, GATE_LEAD=4, delay=10 -> gate rises 4 cycles before first gated word.

Source files
------------

// File: rtl/rf_pulse_gate_pkg.sv
// -----------------------------------------------------------------------------
// rf_pulse_gate_pkg
// Shared types and default widths for the RF transmit-pulse gate.
//   state_t : pulse sequencer states (IDLE -> DELAY -> PULSE -> IDLE)
//   phase_t : phase codes applied to the DDS I/Q lanes
//   DEF_*   : default parameter values for the top and the lane scaler
// -----------------------------------------------------------------------------
package rf_pulse_gate_pkg;

  localparam int DEF_NLANE     = 8;   // samples per clk word
  localparam int DEF_SW        = 16;  // signed sample width
  localparam int DEF_AW        = 16;  // unsigned amplitude width
  localparam int DEF_CW        = 32;  // delay/pulse counter width
  localparam int DEF_GATE_LEAD = 4;   // amplifier gate lead, in cycles

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PH_0   = 2'd0,  // +I
    PH_90  = 2'd1,  // +Q
    PH_180 = 2'd2,  // -I
    PH_270 = 2'd3   // -Q
  } phase_t;

endpackage

// File: rtl/rf_lane_scale.sv
// -----------------------------------------------------------------------------
// rf_lane_scale
// One sample lane of the pulse gate datapath, two register stages:
//   stage 1: pick I or Q by phase, negate with saturation, zero outside window
//   stage 2: result = (s * {1'b0, amplitude}) >>> AW, truncated toward -inf
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_smp       sine sample (signed)
//   q_smp       cosine sample (signed)
//   phase       phase code (phase_t)
//   amplitude   unsigned scale, all-ones ~= unity
//   en          sample is inside the pulse window
//   result      scaled sample, valid two cycles after the input
// -----------------------------------------------------------------------------
module rf_lane_scale
  import rf_pulse_gate_pkg::*;
#(
  parameter int SW = DEF_SW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] i_smp,
  input  logic [SW-1:0] q_smp,
  input  logic [1:0]    phase,
  input  logic [AW-1:0] amplitude,
  input  logic          en,
  output logic [SW-1:0] result
);

  localparam logic [SW-1:0] MOST_NEG = {1'b1, {(SW-1){1'b0}}};
  localparam logic [SW-1:0] MOST_POS = {1'b0, {(SW-1){1'b1}}};

  // -MOST_NEG is not representable; clamp it to MOST_POS.
  function automatic logic [SW-1:0] sat_neg(input logic [SW-1:0] x);
    if (x == MOST_NEG) return MOST_POS;
    else               return -x;
  endfunction

  logic [SW-1:0] sel;
  logic [SW-1:0] s1;

  // NOTE: every output of a combinational block gets a default first, so a
  // path that forgets to assign cannot infer a latch.
  always_comb begin
    sel = i_smp;
    unique case (phase_t'(phase))
      PH_0:    sel = i_smp;
      PH_90:   sel = q_smp;
      PH_180:  sel = sat_neg(i_smp);
      PH_270:  sel = sat_neg(q_smp);
      default: sel = i_smp;
    endcase
  end

  // Both operands sign-extended to the full product width, so the product is
  // exact; amplitude gets a 0 MSB to stay non-negative.
  logic signed [SW+AW:0] a_ext;
  logic signed [SW+AW:0] b_ext;
  logic signed [SW+AW:0] prod;
  logic                  unused_prod_bits;

  assign a_ext = {{(AW+1){s1[SW-1]}}, s1};
  assign b_ext = {{SW{1'b0}}, 1'b0, amplitude};
  assign prod  = a_ext * b_ext;
  // Bits below AW are the truncated fraction; the top bit is pure sign.
  assign unused_prod_bits = ^{prod[SW+AW], prod[AW-1:0]};

  // NOTE: the datapath registers are reset too, because the DAC must see
  // zeros the moment rst_n falls, even mid-pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      result <= '0;
    end else begin
      // A zeroed stage-1 sample forces a zero product, which gates the lane.
      s1     <= en ? sel : '0;
      result <= prod[SW+AW-1:AW];
    end
  end

endmodule

// File: rtl/rf_pulse_gate.sv
// -----------------------------------------------------------------------------
// rf_pulse_gate
// Transmit-pulse gate between the parallel DDS generator and the DAC. Per
// pulse it waits delay_len cycles, then passes pulse_len sample words with the
// programmed phase and amplitude, outputting zeros at all other times.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   dds_i, dds_q  NLANE x SW sine/cosine lanes, lane 0 in the LSBs (earliest)
//   dds_valid     DDS word valid; loss during a pulse aborts it
//   start         pulse request, taken in IDLE with dds_valid=1 and busy=0
//   delay_len     cycles from accept to the first pulse cycle
//   pulse_len     pulse duration in cycles (0: no output, done still pulses)
//   phase_sel     0:+I 1:+Q 2:-I 3:-Q
//   amplitude     unsigned scale
//   busy          sequencer active or gated words still in the pipeline
//   done          one cycle, with the last gated dac_data word
//   err           sticky abort flag, cleared by the next accept
//   dac_data      gated, scaled samples, two cycles after the DDS word
//   dac_valid     dds_valid delayed two cycles
//   gate          amplifier enable
//
// Build option RF_GATE_LEAD_EN: gate rises GATE_LEAD cycles ahead of the first
// gated word (no earlier than the cycle after accept) and falls with the last
// one. Without it, gate is high exactly while gated words are on dac_data.
// -----------------------------------------------------------------------------
module rf_pulse_gate
  import rf_pulse_gate_pkg::*;
#(
  parameter int NLANE     = DEF_NLANE,
  parameter int SW        = DEF_SW,
  parameter int AW        = DEF_AW,
  parameter int CW        = DEF_CW,
  parameter int GATE_LEAD = DEF_GATE_LEAD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NLANE*SW-1:0] dds_i,
  input  logic [NLANE*SW-1:0] dds_q,
  input  logic                dds_valid,
  input  logic                start,
  input  logic [CW-1:0]       delay_len,
  input  logic [CW-1:0]       pulse_len,
  input  logic [1:0]          phase_sel,
  input  logic [AW-1:0]       amplitude,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [NLANE*SW-1:0] dac_data,
  output logic                dac_valid,
  output logic                gate
);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;      // cycles left in DELAY or PULSE
  logic [CW-1:0] pulse_r, pulse_n;
  logic [1:0]    phase_r;
  logic [AW-1:0] amp_r;

  logic accept, abort;
  logic win0, win1, win2;         // pulse-window bit per pipeline stage
  logic done0, done1, done2;
  logic v1, v2;
  logic gate_n;

  // ---------------------------------------------------------------------------
  // Sequencer: next state and stage-0 pipeline bits
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    abort   = 1'b0;
    win0    = 1'b0;
    done0   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && dds_valid && !busy) begin
          accept = 1'b1;
          if (delay_len != '0) begin
            state_n = DELAY;
            cnt_n   = delay_len;
          end else begin
            state_n = PULSE;
            cnt_n   = pulse_len;
          end
        end
      end

      DELAY: begin
        if (!dds_valid) begin
          abort   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CW'(1)) begin
          state_n = PULSE;
          cnt_n   = pulse_r;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end

      PULSE: begin
        if (!dds_valid) begin
          abort   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          // A zero-length pulse still spends one PULSE cycle to issue done.
          win0 = (cnt != '0);
          if (cnt <= CW'(1)) begin
            done0   = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    pulse_n = accept ? pulse_len : pulse_r;
  end

  // ---------------------------------------------------------------------------
  // Gate, computed one cycle early so the amplifier enable is a flop output
  // ---------------------------------------------------------------------------
`ifdef RF_GATE_LEAD_EN
  logic lead_delay;

  // In DELAY the first gated word is cnt+2 cycles away; the extra bit keeps
  // cnt+2 from wrapping at the maximum delay.
  assign lead_delay = (state_n == DELAY) && (pulse_n != '0) &&
                      (({1'b0, cnt_n} + (CW+1)'(2)) <= (CW+1)'(GATE_LEAD));

  // Remaining terms: next cycle's stage 0, 1 and 2 window bits, where a
  // window bit k stages away from dac_data counts only if k <= GATE_LEAD.
  assign gate_n = lead_delay
                | ((GATE_LEAD >= 2) && (state_n == PULSE) && (cnt_n != '0))
                | ((GATE_LEAD >= 1) && win0)
                | win1;
`else
  localparam int unused_gate_lead = GATE_LEAD;

  assign gate_n = win1;
`endif

  // ---------------------------------------------------------------------------
  // State, latches and the window/done/valid pipeline
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of code order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pulse_r <= '0;
      phase_r <= '0;
      amp_r   <= '0;
      err     <= 1'b0;
      win1    <= 1'b0;
      win2    <= 1'b0;
      done1   <= 1'b0;
      done2   <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      gate    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pulse_r <= pulse_n;
      if (accept) begin
        phase_r <= phase_sel;
        amp_r   <= amplitude;
        err     <= 1'b0;
      end else if (abort) begin
        err <= 1'b1;
      end
      win1  <= win0;
      win2  <= win1;
      done1 <= done0;
      done2 <= done1;
      v1    <= dds_valid;
      v2    <= v1;
      gate  <= gate_n;
    end
  end

  assign done      = done2;
  assign dac_valid = v2;
  // Done bits count as pipeline contents so a zero-length pulse stays busy
  // until its done has been delivered.
  assign busy      = (state != IDLE) | win1 | win2 | done1 | done2;

  // ---------------------------------------------------------------------------
  // Lane datapath
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    rf_lane_scale #(
      .SW (SW),
      .AW (AW)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_smp     (dds_i[l*SW +: SW]),
      .q_smp     (dds_q[l*SW +: SW]),
      .phase     (phase_r),
      .amplitude (amp_r),
      .en        (win0),
      .result    (dac_data[l*SW +: SW])
    );
  end

endmodule

// File: tb/tb_rf_pulse_gate.sv
// -----------------------------------------------------------------------------
// tb_rf_pulse_gate
// Bench for rf_pulse_gate. Each pulse is driven cycle by cycle; for every
// driven cycle the expected dac_data/gate/done/dac_valid two cycles later is
// queued and compared by a negedge monitor. Arithmetic corners come from a
// vector table; reset, abort and start-ignore cases are hand sequences.
// Honours RF_GATE_LEAD_EN for the gate expectation.
// -----------------------------------------------------------------------------
module tb_rf_pulse_gate;

  localparam int GATE_LEAD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] dds_i, dds_q;
  logic         dds_valid, start;
  logic [31:0]  delay_len, pulse_len;
  logic [1:0]   phase_sel;
  logic [15:0]  amplitude;
  logic         busy, done, err, dac_valid, gate;
  logic [127:0] dac_data;

  rf_pulse_gate dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dds_i     (dds_i),
    .dds_q     (dds_q),
    .dds_valid (dds_valid),
    .start     (start),
    .delay_len (delay_len),
    .pulse_len (pulse_len),
    .phase_sel (phase_sel),
    .amplitude (amplitude),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dac_data  (dac_data),
    .dac_valid (dac_valid),
    .gate      (gate)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int           cyc;
    logic [127:0] data;
    logic         gate;
    logic         done;
    logic         dv;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      check("scoreboard_missed", 128'(mon_e.cyc), 128'(cyc));
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      check("dac_data",  dac_data,  mon_e.data);
      check("gate",      gate,      mon_e.gate);
      check("done",      done,      mon_e.done);
      check("dac_valid", dac_valid, mon_e.dv);
    end
  end

  // One pulse from accept (k=0) until the pipeline has drained. abort_off >= 1
  // drops dds_valid for one cycle at that offset into the pulse; start stays
  // high for the first 'hold' cycles.
  task automatic run_pulse(input int d, input int p, input logic [1:0] ph,
                           input logic [15:0] amp, input logic [127:0] iw,
                           input logic [127:0] qw, input logic [127:0] ew,
                           input int abort_off, input int hold);
    int   first, abort_k, last_busy;
    logic pul, dn, dv;
    exp_t e;
`ifdef RF_GATE_LEAD_EN
    int   o, lead_start, last_o;
`endif
    first     = 1 + d;
    abort_k   = (abort_off >= 0) ? first + abort_off : -1;
    last_busy = (abort_k >= 0) ? abort_k + 1 : ((p == 0) ? d + 3 : d + p + 2);
    dds_i     = iw;
    dds_q     = qw;
    delay_len = 32'(d);
    pulse_len = 32'(p);
    phase_sel = ph;
    amplitude = amp;
    for (int k = 0; k <= d + p + 4; k++) begin
      check("busy", busy, (k >= 1 && k <= last_busy));
      if (k >= 1) check("err", err, (abort_k >= 0 && k > abort_k));
      start     = (k == 0) || (k < hold);
      dv        = (k != abort_k);
      dds_valid = dv;
      pul = (k >= first) && (k <= d + p) && (abort_k < 0 || k < abort_k);
      dn  = (abort_k < 0) && ((p > 0 && k == d + p) || (p == 0 && k == first));
      e.cyc  = cyc + 2;
      e.data = pul ? ew : '0;
      e.done = dn;
      e.dv   = dv;
`ifdef RF_GATE_LEAD_EN
      o          = k + 2;
      lead_start = (3 + d - GATE_LEAD < 1) ? 1 : 3 + d - GATE_LEAD;
      last_o     = (abort_k >= 0) ? abort_k + 1 : d + p + 2;
      e.gate     = (p > 0) && (o >= lead_start) && (o <= last_o);
`else
      e.gate     = pul;
`endif
      exp_q.push_back(e);
      step();
    end
    start     = 1'b0;
    dds_valid = 1'b1;
    step();
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Arithmetic vectors: every lane carries the same sample
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [1:0]  ph;
    logic [15:0] amp;
    logic [15:0] exp;
  } vec_t;

  vec_t         vecs[12];
  logic [127:0] iw_l, ew_l;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h4000, 16'h1234, 2'd0, 16'hFFFF, 16'h3FFF};
    vecs[1]  = '{16'h8000, 16'h0100, 2'd2, 16'hFFFF, 16'h7FFE}; // saturated negate
    vecs[2]  = '{16'h0700, 16'h1000, 2'd3, 16'h8000, 16'hF800};
    vecs[3]  = '{16'h0050, 16'h2000, 2'd1, 16'h8000, 16'h1000};
    vecs[4]  = '{16'h0001, 16'h5555, 2'd2, 16'hFFFF, 16'hFFFF}; // toward -inf
    vecs[5]  = '{16'h7FFF, 16'h7FFF, 2'd0, 16'h0000, 16'h0000};
    vecs[6]  = '{16'hC000, 16'h0001, 2'd0, 16'h4000, 16'hF000};
    vecs[7]  = '{16'h8000, 16'h0000, 2'd0, 16'hFFFF, 16'h8000};
    vecs[8]  = '{16'h1111, 16'h8000, 2'd3, 16'h8000, 16'h3FFF};
    vecs[9]  = '{16'h0003, 16'h6000, 2'd0, 16'h5555, 16'h0000};
    vecs[10] = '{16'h0000, 16'h7FFF, 2'd1, 16'hFFFF, 16'h7FFE};
    vecs[11] = '{16'h4000, 16'h0000, 2'd2, 16'h8000, 16'hE000};

    rst_n = 1'b0; start = 1'b0; dds_valid = 1'b0;
    dds_i = '0; dds_q = '0; delay_len = '0; pulse_len = '0;
    phase_sel = '0; amplitude = '0;
    #1;
    check("rst_dac_data", dac_data, '0);
    check("rst_gate", gate, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_dac_valid", dac_valid, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    dds_valid = 1'b1;
    step(); step(); step();

    // Baseline pulse: gated words T+6..T+10, done T+10, busy low T+11.
    run_pulse(3, 5, 2'd0, 16'hFFFF, {8{16'h4000}}, {8{16'h1234}}, {8{16'h3FFF}}, -1, 0);

    for (int v = 0; v < 12; v++)
      run_pulse(0, 1, vecs[v].ph, vecs[v].amp, {8{vecs[v].i}}, {8{vecs[v].q}},
                {8{vecs[v].exp}}, -1, 0);

    // Distinct lanes: lane k = 0x100*(k+1), halved.
    for (int k = 0; k < 8; k++) begin
      iw_l[k*16 +: 16] = 16'(16'h0100 * (k + 1));
      ew_l[k*16 +: 16] = 16'(16'h0080 * (k + 1));
    end
    run_pulse(1, 3, 2'd0, 16'h8000, iw_l, {8{16'h7000}}, ew_l, -1, 0);

    // dds_valid lost in the 2nd PULSE cycle; the next accept clears err.
    run_pulse(2, 6, 2'd1, 16'h8000, {8{16'h0123}}, {8{16'h2000}}, {8{16'h1000}}, 1, 0);
    check("err_sticky", err, 1'b1);
    run_pulse(0, 2, 2'd0, 16'hFFFF, {8{16'h4000}}, {8{16'h0000}}, {8{16'h3FFF}}, -1, 0);

    // Zero-length pulse, start held while busy.
    run_pulse(0, 0, 2'd0, 16'hFFFF, {8{16'h4000}}, {8{16'h0000}}, {8{16'h3FFF}}, -1, 4);

    // start without dds_valid is ignored.
    start = 1'b1; dds_valid = 1'b0; delay_len = 32'd0; pulse_len = 32'd3;
    step();
    check("start_no_valid_busy", busy, 1'b0);
    start = 1'b0; dds_valid = 1'b1;
    step(); step();
    check("start_no_valid_gate", gate, 1'b0);
    check("start_no_valid_data", dac_data, '0);

    // Long delay (gate lead case when enabled).
    run_pulse(10, 3, 2'd0, 16'hFFFF, {8{16'h4000}}, {8{16'h0000}}, {8{16'h3FFF}}, -1, 0);

    // Asynchronous reset in the middle of a pulse.
    dds_i = {8{16'h4000}}; dds_q = '0; phase_sel = 2'd0; amplitude = 16'hFFFF;
    delay_len = 32'd0; pulse_len = 32'd20; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("mid_pulse_data", dac_data, {8{16'h3FFF}});
    check("mid_pulse_gate", gate, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_data", dac_data, '0);
    check("async_rst_gate", gate, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_valid", dac_valid, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check("post_rst_busy", busy, 1'b0);
    run_pulse(1, 2, 2'd2, 16'h8000, {8{16'h4000}}, {8{16'h0000}}, {8{16'hE000}}, -1, 0);

    check("scoreboard_drain", 128'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
